// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the 2-way set-associative L1 data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int off_w(input int line_w);
        return clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_w);
        return addr_w - idx_w(sets) - off_w(line_w);
    endfunction

    function automatic int bsel_w(input int word_w);
        return clog2(word_w / 8);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid/dirty/tag/line with combinational read by index.
module dcache_way_array
    import dcache_pkg::*;
#(
    parameter int SETS   = 32,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [clog2(SETS)-1:0] idx_i,
    output logic                   valid_o,
    output logic                   dirty_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic [LINE_W-1:0]      line_o,
    input  logic                   line_we_i,
    input  logic                   fill_i,
    input  logic                   dirty_set_i,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic [LINE_W-1:0]      line_i
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    // A fill installs a clean line; a store hit marks it dirty afterwards.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_i) begin
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end
        if (dirty_set_i) dirty_d[idx_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_i)    tag_q[idx_i]  <= tag_i;
        if (line_we_i) line_q[idx_i] <= line_i;
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate L1 data cache with per-set LRU.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [WORD_W-1:0]     p1_data_i,
    input  logic [WORD_W/8-1:0]   p1_be_i,
    input  logic [ADDR_W-1:0]     p1_addr_i,
    input  logic                  p1_MemRead_i,
    input  logic                  p1_MemWrite_i,
    output logic [WORD_W-1:0]     p1_data_o,
    output logic                  p1_stall_o
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_W);
    localparam int BSEL_W = bsel_w(WORD_W);
    localparam int WSEL_W = OFF_W - BSEL_W;
    localparam int BE_W   = WORD_W / 8;

    logic [TAG_W-1:0]  p1_tag;
    logic [IDX_W-1:0]  p1_idx;
    logic [WSEL_W-1:0] p1_wsel;
    logic              unused_byte_bits;

    assign p1_tag           = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx           = p1_addr_i[OFF_W +: IDX_W];
    assign p1_wsel          = p1_addr_i[BSEL_W +: WSEL_W];
    assign unused_byte_bits = ^p1_addr_i[BSEL_W-1:0];

    state_e            state_q, state_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic              victim_q, victim_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic [1:0]        way_valid, way_dirty, hit_w;
    logic [TAG_W-1:0]  way_tag  [2];
    logic [LINE_W-1:0] way_line [2];
    logic [1:0]        line_we, fill, dirty_set;
    logic [LINE_W-1:0] wr_line;

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way_array #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .idx_i       (p1_idx),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w]),
            .line_we_i   (line_we[w]),
            .fill_i      (fill[w]),
            .dirty_set_i (dirty_set[w]),
            .tag_i       (p1_tag),
            .line_i      (wr_line)
        );
        assign hit_w[w] = way_valid[w] && (way_tag[w] == p1_tag);
    end

    logic              req, hit, hit_way, victim_sel;
    logic [LINE_W-1:0] hit_line, merged_line;
    logic [WORD_W-1:0] hit_word, merged_word;

    // Hits only count in IDLE so a freshly refilled line completes one cycle after REFILL_DONE.
    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign hit        = (state_q == IDLE) && (|hit_w);
    assign hit_way    = hit_w[1];
    assign hit_line   = way_line[hit_way];
    assign hit_word   = hit_line[p1_wsel*WORD_W +: WORD_W];
    assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[p1_idx]);

    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < BE_W; b++) begin
            if (p1_be_i[b]) merged_word[b*8 +: 8] = p1_data_i[b*8 +: 8];
        end
        merged_line = hit_line;
        merged_line[p1_wsel*WORD_W +: WORD_W] = merged_word;
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        victim_d     = victim_q;
        lru_d        = lru_q;
        line_we      = '0;
        fill         = '0;
        dirty_set    = '0;
        wr_line      = merged_line;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    lru_d[p1_idx] = ~hit_way;
                    if (p1_MemWrite_i) begin
                        line_we[hit_way]   = 1'b1;
                        dirty_set[hit_way] = 1'b1;
                    end
                end else if (req) begin
                    victim_d     = victim_sel;
                    mem_enable_d = 1'b1;
                    if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d     = REFILL;
                        mem_write_d = 1'b0;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_write_d = 1'b0;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    wr_line           = mem_data_i;
                    line_we[victim_q] = 1'b1;
                    fill[victim_q]    = 1'b1;
                    mem_enable_d      = 1'b0;
                    state_d           = REFILL_DONE;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            victim_q     <= 1'b0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            victim_q     <= victim_d;
            lru_q        <= lru_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = way_line[victim_q];
    assign mem_addr_o   = (state_q == WRITEBACK) ? {way_tag[victim_q], p1_idx, {OFF_W{1'b0}}}
                                                 : {p1_tag, p1_idx, {OFF_W{1'b0}}};
    assign p1_data_o    = hit ? hit_word : '0;
    assign p1_stall_o   = req & ~hit;

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Next-generation L1 data cache between the CPU data port and the 256-bit data memory.
- Generalises the direct-mapped write-back cache to 2-way set-associative.
- Adds per-set LRU replacement, per-byte write enables, and parametrised line width and set count.
- Write-back, write-allocate; same handshake style on both the memory and CPU sides.

Parameters:
- ADDR_W, 32: byte address width.
- WORD_W, 32: CPU word width; byte enables are WORD_W/8.
- LINE_W, 256: line width in bits; OFF_W = clog2(LINE_W/8).
- SETS, 32: number of sets (power of 2); IDX_W = clog2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  memory completes the current enabled request.
- mem_data_o  out  LINE_W  victim line for write-back.
- mem_addr_o  out  ADDR_W  line-aligned memory address (offset bits zero).
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = write-back, 0 = refill read.
- p1_data_i  in  WORD_W  CPU store data.
- p1_be_i  in  WORD_W/8  store byte enables.
- p1_addr_i  in  ADDR_W  CPU byte address.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  WORD_W  load data.
- p1_stall_o  out  1  CPU must hold its request.

Behaviour:
- Address split: tag=[ADDR_W-1:IDX_W+OFF_W], index=[IDX_W+OFF_W-1:OFF_W], word select=offset[OFF_W-1:clog2(WORD_W/8)]. Low byte bits are ignored (no misalignment trap).
- Storage per way per set: valid, dirty, tag, line. Per set: one lru bit, naming the least-recently-used way.
- Storage read is combinational. Writes occur at the clock edge.
- Request: req = MemRead | MemWrite. If both are asserted, treat it as a write; p1_data_o shows the pre-write word.
- Hit detection:
  - hit_w[i] = valid[i] & tag match. At most one way hits (refill preserves this).
  - hit = |hit_w. p1_stall_o = req & ~hit, combinational.
- Read hit: p1_data_o = selected word of the hitting way in the same cycle. p1_data_o = 0 when there is no hit.
- Write hit: at the edge, merge bytes with p1_be_i=1 into the word. Set dirty=1 even if p1_be_i=0. Same-cycle completion.
- LRU: on every cycle with req & hit, lru[idx] <= ~hitting way. Refill does not touch lru.
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
- IDLE:
  - On req & ~hit, latch the victim way: way0 if invalid, else way1 if invalid, else the way named by lru[idx].
  - If the victim is valid & dirty: go to WRITEBACK with mem_enable_o=1, mem_write_o=1. Otherwise go to REFILL with mem_enable_o=1, mem_write_o=0.
  - mem_enable_o and mem_write_o are registered; they assert the cycle after the miss is seen.
- WRITEBACK:
  - mem_addr_o = {victim tag, idx, 0}; mem_data_o = victim line.
  - On mem_ack_i: mem_write_o <= 0, mem_enable_o stays 1, go to REFILL.
- REFILL:
  - mem_addr_o = {p1 tag, idx, 0}.
  - On mem_ack_i: write mem_data_i into the victim way with valid=1, dirty=0, tag=p1 tag. Set mem_enable_o <= 0 and go to REFILL_DONE.
- REFILL_DONE: go to IDLE. The request now hits and completes as a normal hit; a store sets dirty then.
- Miss latency with 1-cycle ack: clean = 4 stall cycles; dirty = 5.
- mem_ack_i is ignored in IDLE and REFILL_DONE.
- CPU address and control must be stable while p1_stall_o=1; the block does not check this.
- Reset (asserted at any time, including mid-transaction):
  - state=IDLE, mem_enable_o=0, mem_write_o=0 asynchronously.
  - All valid, dirty and lru bits cleared; a dirty line is lost.
  - Data arrays need no reset.
  - mem_addr_o and mem_data_o are don't-care while mem_enable_o=0.

Decomposition:
- Package dcache_pkg holds:
  - state encoding localparams (IDLE=2'd0, WRITEBACK=1, REFILL=2, REFILL_DONE=3);
  - a clog2 function;
  - derived width constants as functions of the parameters.
- Sub-module dcache_way_array (parameters SETS, TAG_W, LINE_W), instantiated twice:
  - contents: valid/dirty/tag/line storage;
  - read: combinational read by index;
  - write: synchronous write with separate line-write and dirty-set controls;
  - reset: async clear of valid/dirty.
- The top holds the FSM, lru bits, victim select, word/byte merge and muxes.

Test Plan (SETS=32, LINE_W=256; A=0x40, B=0x440, C=0x840 all map to set 2):
- Reset, then read A:
  - Required: stall=1; next cycle mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40.
  - Ack with word0=0x11111111: REFILL_DONE, then stall=0 and p1_data_o=0x11111111.
- Write A+4 with data 0xDEADBEEF, be=4'b0011 over old 0xAAAAAAAA: no stall. Reading A+4 next cycle returns 0xAAAABEEF.
- Clean eviction: read A, read B (both ways filled), read A again, then read C.
  - Required: one refill at mem_addr_o=0x840 with no write-back. B's way is replaced; read A still hits.
- Dirty eviction: write B, read A, read C.
  - Required: WRITEBACK at mem_addr_o=0x440 with mem_write_o=1 and mem_data_o = modified B line.
  - After ack: refill at 0x840.
- Ack delayed 10 cycles in REFILL: stall, mem_enable_o and mem_addr_o stay constant for all 10 cycles; completion occurs only after the ack.
- Assert rst_i low during REFILL:
  - Required: mem_enable_o=0 immediately.
  - After release, read A misses again (mem_enable_o=1, addr 0x40).
